// File: rtl/logic_reduce_pipe_if.sv
// Streaming port bundle for logic_reduce_pipe.
// The master side produces operands and consumes results; the slave side is the reduction unit.
//
// Handshake, on both the input and the output channel: a beat transfers on a
// rising clk edge where valid and ready are both high. The producer holds valid,
// and the payload that goes with it, until that edge. ready may depend
// combinationally on the other channel.
interface logic_reduce_pipe_if #(
  parameter int N_INPUTS = 8,
  parameter int WIDTH    = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_op;
  logic [N_INPUTS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [1:0]                out_op;
  logic [WIDTH-1:0]          out_data;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_op, out_data
  );

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, out_op, out_data
  );
endinterface

// File: rtl/logic_reduce_pipe.sv
// Pipelined N-input bitwise reduction (AND/NAND/OR/NOR).
// Each tree level is one register stage. Stages collapse bubbles independently.
//
// Level l (0 = input, LEVELS = output) holds level_cnt(l) words.
// Stage state is published on three flat chains so that every level reads its
// predecessor through constant slices:
//   data_chain : word k of level l sits at [level_off(l) + k*WIDTH +: WIDTH]
//   vld_chain  : bit l is the valid bit of level l
//   op_chain   : [2*l +: 2] is the op of level l
module logic_reduce_pipe #(
  parameter int N_INPUTS = 8,
  parameter int WIDTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_reduce_pipe_if.slave bus
);

  // Number of words held at tree level lvl: halved, rounding up, once per level.
  function automatic int level_cnt(input int lvl);
    int c;
    c = N_INPUTS;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Bit offset of level lvl within data_chain.
  function automatic int level_off(input int lvl);
    int o;
    o = 0;
    for (int i = 0; i < lvl; i++) o = o + level_cnt(i);
    return o * WIDTH;
  endfunction

  localparam int LEVELS  = $clog2(N_INPUTS);
  localparam int CHAIN_W = level_off(LEVELS + 1);

  logic [CHAIN_W-1:0]    data_chain;
  logic [LEVELS:0]       vld_chain;
  logic [2*LEVELS+1:0]   op_chain;
  logic                  in_adv;

  assign data_chain[0 +: N_INPUTS*WIDTH] = bus.in_data;
  assign vld_chain[0]                    = bus.in_valid;
  assign op_chain[1:0]                   = bus.in_op;

  // Stage 1 advances when any stage is empty or the output is consumed.
  // While reset is held the unit refuses input.
  assign in_adv       = bus.out_ready | ~(&vld_chain[LEVELS:1]);
  assign bus.in_ready = rst_n & in_adv;

  // The last stage drives the outputs directly.
  assign bus.out_valid = vld_chain[LEVELS];
  assign bus.out_op    = op_chain[2*LEVELS +: 2];
  assign bus.out_data  = data_chain[level_off(LEVELS) +: WIDTH];

  genvar s;
  generate
    for (s = 1; s <= LEVELS; s++) begin : g_lvl
      localparam int CNT_IN  = level_cnt(s - 1);
      localparam int CNT_OUT = level_cnt(s);
      localparam int OFF_IN  = level_off(s - 1);
      localparam int OFF_OUT = level_off(s);
      localparam bit LAST    = (s == LEVELS);

      logic [CNT_IN*WIDTH-1:0]    src_data;
      logic                       src_vld;
      logic [1:0]                 src_op;
      logic [2*CNT_OUT*WIDTH-1:0] padded;
      logic                       adv;
      logic                       valid_d;
      logic [1:0]                 op_d;
      logic [CNT_OUT*WIDTH-1:0]   data_d;
      logic                       valid_q;
      logic [1:0]                 op_q;
      logic [CNT_OUT*WIDTH-1:0]   data_q;

      assign src_data = data_chain[OFF_IN +: CNT_IN*WIDTH];
      assign src_vld  = vld_chain[s-1];
      assign src_op   = op_chain[2*(s-1) +: 2];

      // Advance if this stage or any later one is empty, or the output drains.
      // The valid bit is copied from upstream, so a stage whose contents move
      // on with nothing behind them loads valid=0.
      assign adv     = bus.out_ready | ~(&vld_chain[LEVELS:s]);
      assign valid_d = src_vld;
      assign op_d    = src_op;

      // An odd word count is padded with the identity of the op's base gate:
      // all-ones for AND/NAND, all-zeros for OR/NOR.
      if (2*CNT_OUT != CNT_IN) begin : g_pad
        assign padded = {{WIDTH{~src_op[1]}}, src_data};
      end else begin : g_even
        assign padded = src_data;
      end

      // Combine adjacent pairs. NAND/NOR inversion is applied only when the final level is loaded.
      always_comb begin
        data_d = '0;
        for (int j = 0; j < CNT_OUT; j++) begin
          if (src_op[1]) begin
            data_d[j*WIDTH +: WIDTH] = padded[2*j*WIDTH +: WIDTH] | padded[(2*j+1)*WIDTH +: WIDTH];
          end else begin
            data_d[j*WIDTH +: WIDTH] = padded[2*j*WIDTH +: WIDTH] & padded[(2*j+1)*WIDTH +: WIDTH];
          end
        end
        if (LAST && src_op[0]) data_d = ~data_d;
      end

      // Stage register: load valid, op and partial result together on advance.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          op_q    <= 2'b00;
          data_q  <= '0;
        end else if (adv) begin
          valid_q <= valid_d;
          op_q    <= op_d;
          data_q  <= data_d;
        end
      end

      assign data_chain[OFF_OUT +: CNT_OUT*WIDTH] = data_q;
      assign vld_chain[s]                         = valid_q;
      assign op_chain[2*s +: 2]                   = op_q;
    end
  endgenerate

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Bench for logic_reduce_pipe. Three instances are built:
//   d=0: N_INPUTS=8, WIDTH=4
//   d=1: N_INPUTS=5, WIDTH=8
//   d=2: N_INPUTS=2, WIDTH=1
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_logic_reduce_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- per-instance stimulus / observation ----------------
  logic         in_valid   [3];
  logic [1:0]   in_op      [3];
  logic [255:0] in_data    [3];
  logic         out_ready  [3];
  logic         in_ready_s [3];
  logic         out_valid_s[3];
  logic [1:0]   out_op_s   [3];
  logic [31:0]  out_data_s [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic_reduce_pipe_if #(.N_INPUTS(8), .WIDTH(4)) if0 ();
  logic_reduce_pipe_if #(.N_INPUTS(5), .WIDTH(8)) if1 ();
  logic_reduce_pipe_if #(.N_INPUTS(2), .WIDTH(1)) if2 ();

  logic_reduce_pipe #(.N_INPUTS(8), .WIDTH(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  logic_reduce_pipe #(.N_INPUTS(5), .WIDTH(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  logic_reduce_pipe #(.N_INPUTS(2), .WIDTH(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if0.in_valid  = in_valid[0];
  assign if0.in_op     = in_op[0];
  assign if0.in_data   = in_data[0][31:0];
  assign if0.out_ready = out_ready[0];
  assign in_ready_s[0]  = if0.in_ready;
  assign out_valid_s[0] = if0.out_valid;
  assign out_op_s[0]    = if0.out_op;
  assign out_data_s[0]  = {28'h0, if0.out_data};

  assign if1.in_valid  = in_valid[1];
  assign if1.in_op     = in_op[1];
  assign if1.in_data   = in_data[1][39:0];
  assign if1.out_ready = out_ready[1];
  assign in_ready_s[1]  = if1.in_ready;
  assign out_valid_s[1] = if1.out_valid;
  assign out_op_s[1]    = if1.out_op;
  assign out_data_s[1]  = {24'h0, if1.out_data};

  assign if2.in_valid  = in_valid[2];
  assign if2.in_op     = in_op[2];
  assign if2.in_data   = in_data[2][1:0];
  assign if2.out_ready = out_ready[2];
  assign in_ready_s[2]  = if2.in_ready;
  assign out_valid_s[2] = if2.out_valid;
  assign out_op_s[2]    = if2.out_op;
  assign out_data_s[2]  = {31'h0, if2.out_data};

  function automatic int dut_n(input int d);
    case (d)
      0:       return 8;
      1:       return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int dut_w(input int d);
    case (d)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int dut_lat(input int d);
    case (d)
      0:       return 3;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Linear fold over all operands, then the optional inversion.
  function automatic logic [31:0] ref_reduce(input int n, input int w, input logic [1:0] op,
                                             input logic [255:0] data);
    logic [31:0] mask, acc, opnd;
    mask = (32'h1 << w) - 32'h1;
    acc  = op[1] ? 32'h0 : mask;
    for (int k = 0; k < n; k++) begin
      opnd = 32'(data >> (k * w)) & mask;
      acc  = op[1] ? (acc | opnd) : (acc & opnd);
    end
    if (op[0]) acc = ~acc & mask;
    return acc;
  endfunction

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic [33:0] exp_q2[$];

  function automatic void q_push(input int d, input logic [33:0] v);
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [33:0] q_pop(input int d);
    case (d)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: checks every output handshake and held-output stability for each instance.
  logic        held      [3];
  logic [1:0]  held_op   [3];
  logic [31:0] held_data [3];

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      for (int d = 0; d < 3; d++) held[d] = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (held[d]) begin
          check($sformatf("hold%0d", d), {31'h0, out_valid_s[d], out_op_s[d], out_data_s[d]},
                {31'h0, 1'b1, held_op[d], held_data[d]});
        end
        if (out_valid_s[d] && out_ready[d]) begin
          if (q_size(d) == 0) begin
            check($sformatf("unexpected_out%0d", d), 64'(out_valid_s[d]), 64'h0);
          end else begin
            check($sformatf("out%0d", d), {30'h0, out_op_s[d], out_data_s[d]}, {30'h0, q_pop(d)});
          end
        end
        held[d]      = out_valid_s[d] && !out_ready[d];
        held_op[d]   = out_op_s[d];
        held_data[d] = out_data_s[d];
        if (in_valid[d] && in_ready_s[d]) begin
          q_push(d, {in_op[d], ref_reduce(dut_n(d), dut_w(d), in_op[d], in_data[d])});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 ns after a rising edge.
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic beat(input int d, input logic [1:0] op, input logic [255:0] data);
    int guard;
    guard = 0;
    in_valid[d] = 1'b1;
    in_op[d]    = op;
    in_data[d]  = data;
    @(negedge clk);
    while (!in_ready_s[d] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check($sformatf("accept_timeout%0d", d), 64'(in_ready_s[d]), 64'h1);
    sync();
    in_valid[d] = 1'b0;
  endtask

  // Single beat into an idle pipe with out_ready=1: check latency, result and op.
  task automatic lat_check(input int d, input logic [1:0] op, input logic [255:0] data,
                           input logic [31:0] exp_data, input string name);
    int k;
    beat(d, op, data);
    k = 0;
    @(negedge clk);
    k++;
    while (!out_valid_s[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_lat"}, 64'(k), 64'(dut_lat(d)));
    check({name, "_data"}, 64'(out_data_s[d]), 64'(exp_data));
    check({name, "_op"}, 64'(out_op_s[d]), 64'(op));
    sync();
  endtask

  // ---------------- tests ----------------
  task automatic t_reset();
    sync();
    sync();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_in_ready%0d", d), 64'(in_ready_s[d]), 64'h0);
      check($sformatf("rst_out_valid%0d", d), 64'(out_valid_s[d]), 64'h0);
      check($sformatf("rst_out_data%0d", d), 64'(out_data_s[d]), 64'h0);
      check($sformatf("rst_out_op%0d", d), 64'(out_op_s[d]), 64'h0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("post_rst_in_ready%0d", d), 64'(in_ready_s[d]), 64'h1);
    sync();
  endtask

  task automatic t_model_pins();
    check("model_or8",   64'(ref_reduce(8, 4, 2'b10, 256'h21)), 64'h3);
    check("model_nand5", 64'(ref_reduce(5, 8, 2'b01, 256'hA5A5A5A5A5)), 64'h5A);
    check("model_nor2",  64'(ref_reduce(2, 1, 2'b11, 256'h0)), 64'h1);
  endtask

  task automatic t_all_ops();
    logic [3:0] exp4 [4];
    exp4[0] = 4'h0;
    exp4[1] = 4'hF;
    exp4[2] = 4'h3;
    exp4[3] = 4'hC;
    fork
      begin
        for (int i = 0; i < 4; i++) beat(0, 2'(i), 256'h21);
      end
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid_s[0] && k < 20) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < 4; i++) begin
          check($sformatf("ops_valid%0d", i), 64'(out_valid_s[0]), 64'h1);
          check($sformatf("ops_data%0d", i), 64'(out_data_s[0]), 64'(exp4[i]));
          check($sformatf("ops_op%0d", i), 64'(out_op_s[0]), 64'(i));
          if (i < 3) @(negedge clk);
        end
      end
    join
    sync();
  endtask

  task automatic t_backpressure();
    int acc;
    acc = 0;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_op[0]   = 2'(i);
      in_data[0] = 256'($urandom);
      @(negedge clk);
      if (in_ready_s[0]) acc++;
      sync();
    end
    check("bp_accepts", 64'(acc), 64'h3);
    check("bp_in_ready_low", 64'(in_ready_s[0]), 64'h0);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_drain%0d", i), 64'(out_valid_s[0]), 64'h1);
    end
    @(negedge clk);
    check("bp_drained", 64'(out_valid_s[0]), 64'h0);
    sync();
  endtask

  task automatic t_random();
    int  sent;
    int  cyc;
    logic acc;
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      out_ready[0] = ($urandom_range(0, 3) != 0);
      if (!in_valid[0] || acc) begin
        in_valid[0] = ($urandom_range(0, 4) != 0);
        in_op[0]    = 2'($urandom_range(0, 3));
        in_data[0]  = 256'($urandom);
      end
      @(negedge clk);
      acc = in_valid[0] && in_ready_s[0];
      if (acc) sent++;
      sync();
      cyc++;
    end
    check("rand_sent", 64'(sent), 64'd1000);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    cyc = 0;
    while (q_size(0) != 0 && cyc < 50) begin
      sync();
      cyc++;
    end
    check("rand_drained", 64'(q_size(0)), 64'h0);
  endtask

  task automatic t_reset_midflight();
    out_ready[0] = 1'b0;
    beat(0, 2'b00, 256'h1234_5678);
    beat(0, 2'b10, 256'h0000_0F00);
    sync();
    check("mid_out_valid_before", 64'(out_valid_s[0]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid_drop", 64'(out_valid_s[0]), 64'h0);
    check("mid_in_ready_low", 64'(in_ready_s[0]), 64'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("mid_in_ready_first", 64'(in_ready_s[0]), 64'h1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mid_no_stale%0d", i), 64'(out_valid_s[0]), 64'h0);
      @(negedge clk);
    end
    sync();
    out_ready[0] = 1'b1;
  endtask

  task automatic t_min_config();
    // Truth table for (op, {b,a}): nibble op holds the results for {b,a} = 3..0.
    logic [15:0] tt;
    tt = 16'b0001_1110_0111_1000;
    for (int op = 0; op < 4; op++) begin
      for (int a = 0; a < 4; a++) begin
        lat_check(2, 2'(op), 256'(a), 32'(tt[op*4 + a]), $sformatf("min_op%0d_in%0d", op, a));
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_op[d]     = 2'b00;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
    end
    t_reset();
    t_model_pins();
    lat_check(0, 2'b00, 256'hFFFF_FFFF, 32'hF, "lat8_and_all_f");
    lat_check(0, 2'b00, 256'hFF7F_FFFF, 32'h7, "lat8_and_op5_7");
    t_all_ops();
    lat_check(1, 2'b00, 256'hA5A5A5A5A5, 32'hA5, "odd5_and");
    lat_check(1, 2'b01, 256'hA5A5A5A5A5, 32'h5A, "odd5_nand");
    lat_check(1, 2'b10, 256'hA5A5A5A5A5, 32'hA5, "odd5_or");
    lat_check(1, 2'b11, 256'hA5A5A5A5A5, 32'h5A, "odd5_nor");
    t_backpressure();
    t_random();
    t_reset_midflight();
    t_min_config();
    repeat (5) sync();
    for (int d = 0; d < 3; d++) check($sformatf("final_empty%0d", d), 64'(q_size(d)), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so a stuck handshake cannot hang the run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests so far %0d", n_tests);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/logic_reduce_pipe.md
Name: logic_reduce_pipe

Overview:
- Parametrised, pipelined N-input bitwise reduction unit; successor to the fixed two-input gate cells.
- Reduces N_INPUTS operand words of WIDTH bits each to a single WIDTH-bit word.
- Operation is selectable per transaction: AND, NAND, OR or NOR.
- Valid/ready handshake on both sides, with per-stage bubble collapsing, so it drops into streaming datapaths in the same design.

Parameters:
- N_INPUTS, 8, number of operand words; legal range 2..64.
- WIDTH, 4, bits per operand and result; legal range 1..32.
- LEVELS, derived as clog2(N_INPUTS), not overridable; number of tree levels, equal to the number of pipeline registers.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit accepts a transaction this cycle.
- in_op  input  2  operation: 00 AND, 01 NAND, 10 OR, 11 NOR.
- in_data  input  N_INPUTS*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_op  output  2  op that produced out_data.
- out_data  output  WIDTH  reduction result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits, stage data and stage op registers clear to 0.
  - out_valid=0, out_data=0, out_op=0.
  - in_ready is forced to 0 while rst_n is low.
  - Reset mid-operation discards every in-flight transaction; nothing partial is emitted after release.
- After reset release, in_ready=1 on the first cycle (pipeline empty).
- Pipeline structure:
  - Stage s (1..LEVELS) registers tree level s; each level combines adjacent pairs with a 2-input bitwise AND (ops 00/01) or OR (ops 10/11).
  - Odd element counts at any level are padded with the identity value: all-ones for AND/NAND, all-zeros for OR/NOR.
  - in_op is captured with the data in stage 1 and travels with it; mixed ops may be in flight at the same time.
  - Inversion for NAND/NOR is applied when the final stage is loaded, so out_data is already inverted.
  - Stage LEVELS drives the outputs directly.
- Latency: LEVELS cycles from an accepted input (in_valid and in_ready at a rising edge) to out_valid, with no stall.
  - N_INPUTS=8 gives 3 cycles; N_INPUTS=2 gives 1 cycle.
- Handshake:
  - Stage s advances (loads from stage s-1, or from the input for s=1) when stage s is empty or stage s+1 advances.
  - For the last stage, "stage s+1 advances" means out_ready.
  - in_ready = stage 1 advance condition, computed combinationally; it may depend on out_ready.
  - Throughput is one transaction per cycle while out_ready stays high.
  - out_valid is held, with out_data and out_op stable, until out_ready is sampled high.
  - A stage that is not loaded while its contents move forward clears its valid bit.
  - Valid data is never dropped or duplicated.
- Bubble collapsing: an empty internal stage accepts new data even while out_ready=0.
  - With out_ready held low, the pipe absorbs exactly LEVELS transactions before in_ready falls.
- Simultaneous accept and emit on the same edge is legal; the full pipe stays full.
- Data accepted while in_valid=0 is ignored; the stage loads valid=0.
- No protocol checks; in_data is don't-care when in_valid=0.

Test Plan:
- Reset and basic latency (N_INPUTS=8, WIDTH=4): in_data all 4'hF, op=00, single beat.
  - out_valid rises exactly 3 cycles later with out_data=4'hF and out_op=00.
  - Repeat with operand 5 = 4'h7: out_data=4'h7.
- All four ops on one operand set (operands 4'h1, 4'h2, 4'h0 ×6), back-to-back, out_ready=1.
  - Results in order: AND=0, NAND=F, OR=3, NOR=C.
  - out_op matches each result; one result per cycle.
- Odd N padding (N_INPUTS=5, WIDTH=8), all operands 8'hA5:
  - AND gives A5; NAND gives 5A; OR gives A5.
  - Latency is 3 cycles.
- Backpressure: out_ready=0 while driving in_valid continuously.
  - Exactly 3 transactions are accepted, then in_ready=0.
  - Raising out_ready drains them in order, one per cycle, with no loss or duplication.
  - Scoreboard must match a reference model over 1000 random beats with random out_ready.
- Reset mid-flight: assert rst_n low asynchronously between clock edges with 2 transactions in flight.
  - out_valid drops immediately and in_ready=0.
  - After release, no stale result appears and in_ready=1 on the first cycle.
- Minimum config (N_INPUTS=2, WIDTH=1):
  - Exhaustive sweep of the 4 operand combinations × 4 ops.
  - Every result matches the 2-input truth table with 1-cycle latency.
